// File: rtl/keypad_hex_entry.sv
// 4x4 matrix keypad scanner with debounce, one-shot key acceptance and a
// four-digit hex operand shift register.
module keypad_hex_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  kp_row,
  output logic [3:0]  kp_col,
  input  logic        entry_clr,
  output logic [15:0] operand,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [2:0]  digit_count
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_ACCEPT,
    S_RELEASE
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    row_meta, row_sync;
  logic [TW-1:0] tick_cnt;
  logic          scan_tick;
  logic [1:0]    col_idx, col_nxt;
  logic [1:0]    lat_row, lat_row_nxt;
  logic [CW-1:0] deb_cnt, deb_nxt, deb_inc;
  logic [CW-1:0] rel_cnt, rel_nxt, rel_inc;
  logic [1:0]    low_row;
  logic          any_low;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
      tick_cnt <= '0;
    end else begin
      row_meta <= kp_row;
      row_sync <= row_meta;
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  assign scan_tick = (tick_cnt == TICK_LAST);
  assign kp_col    = ~(4'b0001 << col_idx);
  assign key_valid = (state == S_ACCEPT);
  assign deb_inc   = deb_cnt + 1'b1;
  assign rel_inc   = rel_cnt + 1'b1;

  always_comb begin
    any_low = ~&row_sync;
    low_row = 2'd0;
    if (!row_sync[0])      low_row = 2'd0;
    else if (!row_sync[1]) low_row = 2'd1;
    else if (!row_sync[2]) low_row = 2'd2;
    else if (!row_sync[3]) low_row = 2'd3;
  end

  // The column index stays parked from detection until release completes,
  // so it doubles as the latched column of the key being handled.
  always_comb begin
    state_nxt   = state;
    col_nxt     = col_idx;
    lat_row_nxt = lat_row;
    deb_nxt     = deb_cnt;
    rel_nxt     = rel_cnt;
    case (state)
      S_SCAN: begin
        if (scan_tick) begin
          if (any_low) begin
            lat_row_nxt = low_row;
            deb_nxt     = '0;
            state_nxt   = S_DEBOUNCE;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (scan_tick) begin
          if (!row_sync[lat_row]) begin
            deb_nxt = deb_inc;
            if (deb_inc == DEB_LAST) state_nxt = S_ACCEPT;
          end else begin
            state_nxt = S_SCAN;
            col_nxt   = col_idx + 2'd1;
          end
        end
      end
      S_ACCEPT: begin
        rel_nxt   = '0;
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (scan_tick) begin
          if (any_low) begin
            rel_nxt = '0;
          end else if (rel_inc == DEB_LAST) begin
            rel_nxt   = '0;
            state_nxt = S_SCAN;
            col_nxt   = col_idx + 2'd1;
          end else begin
            rel_nxt = rel_inc;
          end
        end
      end
      default: state_nxt = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_SCAN;
      col_idx <= '0;
      lat_row <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_idx <= col_nxt;
      lat_row <= lat_row_nxt;
      deb_cnt <= deb_nxt;
      rel_cnt <= rel_nxt;
    end
  end

  // key_code is loaded on entry to ACCEPT so it is already valid alongside key_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_code    <= '0;
      operand     <= '0;
      digit_count <= '0;
    end else begin
      if (state == S_DEBOUNCE && state_nxt == S_ACCEPT)
        key_code <= key_map(lat_row, col_idx);
      if (entry_clr) begin
        operand     <= '0;
        digit_count <= '0;
      end else if (state == S_ACCEPT) begin
        operand <= {operand[11:0], key_code};
        if (digit_count < 3'd4) digit_count <= digit_count + 3'd1;
      end
    end
  end

endmodule

// File: doc/keypad_hex_entry.md
KEYPAD_HEX_ENTRY -- requirements
Module: keypad_hex_entry

Interface
REQ-001 Parameter SCAN_DIV, default 100000, SHALL set the clk cycles per scan tick (1 kHz at 100 MHz).
REQ-002 Parameter DEBOUNCE_TICKS, default 20, SHALL set the consecutive stable scan ticks needed to accept a press or a release.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 kp_row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 kp_col  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 entry_clr  input  1  synchronous clear of the entered operand.
REQ-008 operand  output  16  last four hex digits entered, newest in [3:0].
REQ-009 key_code  output  4  hex value of the most recently accepted key.
REQ-010 key_valid  output  1  one-clk pulse per accepted key.
REQ-011 digit_count  output  3  digits entered since clear, saturating at 4.

Function
REQ-012 kp_row SHALL pass through a 2-flop synchronizer before any use; all row references below mean the synchronized value.
REQ-013 The tick counter SHALL run 0..SCAN_DIV-1 and wrap; scan_tick SHALL be high for the one cycle when it equals SCAN_DIV-1.
REQ-014 The column index (0..3) SHALL drive kp_col as 1110, 1101, 1011, 0111 for columns 0..3.
REQ-015 The FSM SHALL have four states: SCAN, DEBOUNCE, ACCEPT and RELEASE.
REQ-016 In SCAN, on scan_tick with all rows high, the column index SHALL advance, wrapping 3 to 0.
REQ-017 In SCAN, on scan_tick with any row low, the FSM SHALL latch the column and the lowest-index low row, clear the debounce count and enter DEBOUNCE; the column SHALL hold.
REQ-018 In DEBOUNCE, each scan_tick with the latched row still low SHALL increment the debounce count.
REQ-019 In DEBOUNCE, when the debounce count reaches DEBOUNCE_TICKS, the FSM SHALL enter ACCEPT.
REQ-020 In DEBOUNCE, a scan_tick with the latched row high SHALL return the FSM to SCAN and advance the column.
REQ-021 ACCEPT SHALL last exactly one clk. In that cycle:
- key_valid = 1;
- key_code = the key mapped from the latched position;
- operand <= {operand[11:0], key_code};
- digit_count increments, saturating at 4.
The FSM SHALL then enter RELEASE.
REQ-022 Key map [row][col]:
- row0: 1, 2, 3, A
- row1: 4, 5, 6, B
- row2: 7, 8, 9, C
- row3: 0, F, E, D
REQ-023 In RELEASE, each scan_tick with all rows high SHALL increment the release count; any low row SHALL zero it.
REQ-024 In RELEASE, when the release count reaches DEBOUNCE_TICKS, the FSM SHALL return to SCAN and advance the column.
REQ-025 A held key SHALL produce exactly one key_valid; no auto-repeat.
REQ-026 A press on a second column while in RELEASE SHALL be ignored until release completes.
REQ-027 entry_clr SHALL set operand to 0 and digit_count to 0 on the next edge.
REQ-028 If entry_clr coincides with ACCEPT, the clear SHALL win for operand and digit_count; key_valid and key_code SHALL still update.
REQ-029 A 5th and later digit SHALL shift out operand[15:12]; digit_count SHALL stay 4.
REQ-030 key_valid SHALL never assert on two consecutive clk cycles.

Reset
REQ-031 While rst_n = 0 at a clk edge, the following SHALL apply, overriding all other activity:
- state = SCAN; column = 0 (kp_col = 1110);
- tick, debounce and release counts = 0;
- operand = 0000h, key_code = 0, key_valid = 0, digit_count = 0;
- synchronizer flops = 1111.
REQ-032 Reset asserted in DEBOUNCE or RELEASE SHALL abandon the key; no key_valid SHALL follow from it.

Verification (bench uses SCAN_DIV = 10, DEBOUNCE_TICKS = 4)
REQ-033 Press and release:
- Stimulus: hold row1 low while kp_col = 1011, hold it for 10 ticks, then release.
- Response: one key_valid with key_code = 6; operand = 0006h; digit_count = 1.
REQ-034 Four-digit entry:
- Stimulus: keys 1, A, 0, D, then E.
- Response: operand = 1A0Dh after four keys and A0DEh after five; digit_count = 4 at the end.
REQ-035 Bounce:
- Stimulus: row low for 2 ticks, high for 1, then stable low for 6 ticks.
- Response: exactly one key_valid; no key_valid during the bounce.
REQ-036 Hold:
- Stimulus: key held for 100 ticks, and the row re-bounces low within 3 ticks of release.
- Response: exactly one key_valid; RELEASE restarts its count.
REQ-037 Clear collision:
- Stimulus: entry_clr asserted in the ACCEPT cycle of key 5, with operand = 1234h beforehand.
- Response: operand = 0000h; digit_count = 0; key_code = 5; key_valid pulses.
REQ-038 Reset mid-debounce:
- Stimulus: rst_n low for 1 clk during DEBOUNCE.
- Response: kp_col = 1110 on the next cycle; all outputs at reset values; no key_valid.
